// File: rtl/spi_display_receiver.sv
// SPI display-controller responder: decodes CASET/PASET/RAMWR and turns RAMWR
// pixel data into framebuffer write strobes with x, y and RGB565 colour.
module spi_display_receiver #(
  parameter int unsigned WIDTH  = 240,
  parameter int unsigned HEIGHT = 320
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_mosi,
  input  logic        i_dc,
  input  logic        i_cs,
  output logic        o_cmd_valid,
  output logic [7:0]  o_cmd,
  output logic        o_pix_we,
  output logic [8:0]  o_pix_x,
  output logic [8:0]  o_pix_y,
  output logic [15:0] o_pix_color,
  output logic        o_err
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StCaset  = 3'd1;
  localparam logic [2:0] StPaset  = 3'd2;
  localparam logic [2:0] StRamwr  = 3'd3;
  localparam logic [2:0] StIgnore = 3'd4;

  localparam logic [9:0] WLim = 10'(WIDTH);
  localparam logic [9:0] HLim = 10'(HEIGHT);

  logic [2:0]  bit_cnt_q;
  logic [6:0]  shift_q;
  logic        byte_done;
  logic [7:0]  rx_byte;

  logic [2:0]  state_q, state_d;
  logic [2:0]  param_idx_q, param_idx_d;
  logic [23:0] par_q, par_d;
  logic [8:0]  sc_q, sc_d, ec_q, ec_d, sp_q, sp_d, ep_q, ep_d;
  logic [8:0]  x_q, x_d, y_q, y_d;
  logic        hi_pend_q, hi_pend_d;
  logic [7:0]  hi_byte_q, hi_byte_d;
  logic        cmd_valid_d, pix_we_d, err_d;
  logic [7:0]  cmd_d;
  logic [8:0]  pix_x_d, pix_y_d;
  logic [15:0] pix_color_d;
  logic [8:0]  win_start, win_end;
  logic [9:0]  win_lim;

  // The completing bit is still on i_mosi, so the byte is decoded on its 8th edge.
  assign byte_done = !i_cs && (bit_cnt_q == 3'd7);
  assign rx_byte   = {shift_q, i_mosi};

  always_comb begin
    state_d     = state_q;
    param_idx_d = param_idx_q;
    par_d       = par_q;
    sc_d        = sc_q;
    ec_d        = ec_q;
    sp_d        = sp_q;
    ep_d        = ep_q;
    x_d         = x_q;
    y_d         = y_q;
    hi_pend_d   = hi_pend_q;
    hi_byte_d   = hi_byte_q;
    cmd_valid_d = 1'b0;
    cmd_d       = o_cmd;
    pix_we_d    = 1'b0;
    pix_x_d     = o_pix_x;
    pix_y_d     = o_pix_y;
    pix_color_d = o_pix_color;
    err_d       = o_err;
    win_start   = {par_q[16], par_q[15:8]};
    win_end     = {par_q[0], rx_byte};
    win_lim     = (state_q == StCaset) ? WLim : HLim;

    if (i_cs) begin
      hi_pend_d = 1'b0;
    end else if (byte_done && !i_dc) begin
      cmd_valid_d = 1'b1;
      cmd_d       = rx_byte;
      param_idx_d = 3'd0;
      hi_pend_d   = 1'b0;
      case (rx_byte)
        8'h2A:   state_d = StCaset;
        8'h2B:   state_d = StPaset;
        8'h2C: begin
          state_d = StRamwr;
          x_d     = sc_q;
          y_d     = sp_q;
        end
        default: state_d = StIgnore;
      endcase
    end else if (byte_done) begin
      case (state_q)
        StCaset, StPaset: begin
          if (param_idx_q < 3'd3) begin
            par_d       = {par_q[15:0], rx_byte};
            param_idx_d = param_idx_q + 3'd1;
          end else if (param_idx_q == 3'd3) begin
            param_idx_d = 3'd4;
            if ((win_start > win_end) || ({1'b0, win_end} >= win_lim)) begin
              err_d = 1'b1;
            end else if (state_q == StCaset) begin
              sc_d = win_start;
              ec_d = win_end;
            end else begin
              sp_d = win_start;
              ep_d = win_end;
            end
          end
        end
        StRamwr: begin
          if (!hi_pend_q) begin
            hi_pend_d = 1'b1;
            hi_byte_d = rx_byte;
          end else begin
            hi_pend_d   = 1'b0;
            pix_we_d    = 1'b1;
            pix_x_d     = x_q;
            pix_y_d     = y_q;
            pix_color_d = {hi_byte_q, rx_byte};
            if (({1'b0, x_q} >= WLim) || ({1'b0, y_q} >= HLim)) begin
              err_d = 1'b1;
            end
            if (x_q == ec_q) begin
              x_d = sc_q;
              y_d = (y_q == ep_q) ? sp_q : y_q + 9'd1;
            end else begin
              x_d = x_q + 9'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bit_cnt_q   <= 3'd0;
      shift_q     <= 7'd0;
      state_q     <= StIdle;
      param_idx_q <= 3'd0;
      par_q       <= 24'd0;
      sc_q        <= 9'd0;
      ec_q        <= 9'(WIDTH - 1);
      sp_q        <= 9'd0;
      ep_q        <= 9'(HEIGHT - 1);
      x_q         <= 9'd0;
      y_q         <= 9'd0;
      hi_pend_q   <= 1'b0;
      hi_byte_q   <= 8'd0;
      o_cmd_valid <= 1'b0;
      o_cmd       <= 8'd0;
      o_pix_we    <= 1'b0;
      o_pix_x     <= 9'd0;
      o_pix_y     <= 9'd0;
      o_pix_color <= 16'd0;
      o_err       <= 1'b0;
    end else begin
      if (i_cs) begin
        bit_cnt_q <= 3'd0;
      end else begin
        bit_cnt_q <= bit_cnt_q + 3'd1;
        shift_q   <= {shift_q[5:0], i_mosi};
      end
      state_q     <= state_d;
      param_idx_q <= param_idx_d;
      par_q       <= par_d;
      sc_q        <= sc_d;
      ec_q        <= ec_d;
      sp_q        <= sp_d;
      ep_q        <= ep_d;
      x_q         <= x_d;
      y_q         <= y_d;
      hi_pend_q   <= hi_pend_d;
      hi_byte_q   <= hi_byte_d;
      o_cmd_valid <= cmd_valid_d;
      o_cmd       <= cmd_d;
      o_pix_we    <= pix_we_d;
      o_pix_x     <= pix_x_d;
      o_pix_y     <= pix_y_d;
      o_pix_color <= pix_color_d;
      o_err       <= err_d;
    end
  end

endmodule

// File: tb/tb_spi_display_receiver.sv
// Directed bench for spi_display_receiver: expected commands and pixels are queued
// as stimulus is sent and checked when the DUT strobes them.
module tb_spi_display_receiver;

  typedef struct {
    logic [8:0]  x;
    logic [8:0]  y;
    logic [15:0] c;
  } pix_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mosi = 1'b0;
  logic        dc = 1'b0;
  logic        cs = 1'b1;
  logic        cmd_valid;
  logic [7:0]  cmd;
  logic        pix_we;
  logic [8:0]  pix_x;
  logic [8:0]  pix_y;
  logic [15:0] pix_color;
  logic        err;

  int   checks = 0;
  int   errors = 0;
  pix_t pix_q[$];
  logic [7:0] cmd_q[$];

  spi_display_receiver #(
    .WIDTH (240),
    .HEIGHT(320)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_mosi     (mosi),
    .i_dc       (dc),
    .i_cs       (cs),
    .o_cmd_valid(cmd_valid),
    .o_cmd      (cmd),
    .o_pix_we   (pix_we),
    .o_pix_x    (pix_x),
    .o_pix_y    (pix_y),
    .o_pix_color(pix_color),
    .o_err      (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic is_data);
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk);
      cs   = 1'b0;
      dc   = is_data;
      mosi = b[i];
    end
  endtask

  task automatic send_cmd(input logic [7:0] b);
    cmd_q.push_back(b);
    send_byte(b, 1'b0);
  endtask

  task automatic send_pix(input logic [15:0] c, input logic [8:0] x, input logic [8:0] y);
    pix_t p;
    p.x = x;
    p.y = y;
    p.c = c;
    pix_q.push_back(p);
    send_byte(c[15:8], 1'b1);
    send_byte(c[7:0], 1'b1);
  endtask

  task automatic send_win(input logic [7:0] c, input logic [15:0] s, input logic [15:0] e);
    send_cmd(c);
    send_byte(s[15:8], 1'b1);
    send_byte(s[7:0], 1'b1);
    send_byte(e[15:8], 1'b1);
    send_byte(e[7:0], 1'b1);
  endtask

  task automatic cs_idle(input int n);
    repeat (n) begin
      @(negedge clk);
      cs = 1'b1;
    end
  endtask

  // Bounded wait for every queued expectation to be matched by a DUT strobe.
  task automatic drain(input string tag);
    int n = 0;
    while ((pix_q.size() != 0 || cmd_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, pix_q.size() + cmd_q.size(), 0);
    cs_idle(2);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cmd_valid"}, {31'd0, cmd_valid}, 0);
    check({tag, "_cmd"}, {24'd0, cmd}, 0);
    check({tag, "_pix_we"}, {31'd0, pix_we}, 0);
    check({tag, "_pix_xy"}, {14'd0, pix_x, pix_y}, 0);
    check({tag, "_color"}, {16'd0, pix_color}, 0);
    check({tag, "_err"}, {31'd0, err}, 0);
  endtask

  always @(negedge clk) begin
    if (cmd_valid) begin
      if (cmd_q.size() == 0) begin
        check("unexpected_cmd", {24'd0, cmd}, 32'hFFFF_FFFF);
      end else begin
        check("cmd", {24'd0, cmd}, {24'd0, cmd_q.pop_front()});
      end
    end
    if (pix_we) begin
      if (pix_q.size() == 0) begin
        check("unexpected_pix", {14'd0, pix_x, pix_y}, 32'hFFFF_FFFF);
      end else begin
        pix_t p;
        p = pix_q.pop_front();
        check("pix_x", {23'd0, pix_x}, {23'd0, p.x});
        check("pix_y", {23'd0, pix_y}, {23'd0, p.y});
        check("pix_color", {16'd0, pix_color}, {16'd0, p.c});
      end
    end
  end

  initial begin
    // Reset state
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_all_zero("reset");

    // Vertical line at x=5, y=5..10
    send_win(8'h2A, 16'h0005, 16'h0005);
    send_win(8'h2B, 16'h0005, 16'h000A);
    send_cmd(8'h2C);
    for (int i = 0; i < 6; i++) send_pix(16'hF800, 9'd5, 9'(5 + i));
    drain("vline_drain");
    check("vline_err", {31'd0, err}, 0);

    // Window wrap over a 2x2 window
    send_win(8'h2A, 16'h0000, 16'h0001);
    send_win(8'h2B, 16'h0000, 16'h0001);
    send_cmd(8'h2C);
    send_pix(16'h1111, 9'd0, 9'd0);
    send_pix(16'h2222, 9'd1, 9'd0);
    send_pix(16'h3333, 9'd0, 9'd1);
    send_pix(16'h4444, 9'd1, 9'd1);
    send_pix(16'h5555, 9'd0, 9'd0);
    drain("wrap_drain");

    // Partial byte discarded by CS, then RAMWR restarts at (SC,SP)
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      cs   = 1'b0;
      dc   = 1'b0;
      mosi = 1'b1;
    end
    cs_idle(1);
    send_cmd(8'h2C);
    send_pix(16'hABCD, 9'd0, 9'd0);
    drain("partial_drain");
    check("partial_last_cmd", {24'd0, cmd}, 32'h2C);

    // Pending high byte dropped by CS toggle; position continues at (1,0)
    send_byte(8'hAB, 1'b1);
    cs_idle(2);
    send_pix(16'h001F, 9'd1, 9'd0);
    send_pix(16'h001F, 9'd0, 9'd1);
    drain("pending_drain");
    check("pending_err", {31'd0, err}, 0);

    // Bad window keeps the previous columns 3..7
    send_win(8'h2A, 16'h0003, 16'h0007);
    drain("goodwin_drain");
    check("goodwin_err", {31'd0, err}, 0);
    send_win(8'h2A, 16'h000A, 16'h0005);
    drain("badwin_drain");
    check("badwin_err", {31'd0, err}, 1);
    send_cmd(8'h2C);
    send_pix(16'h07E0, 9'd3, 9'd0);
    send_pix(16'h07E1, 9'd4, 9'd0);
    drain("badwin_ramwr_drain");
    check("err_sticky", {31'd0, err}, 1);

    // Reset in the middle of a byte
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cs   = 1'b0;
      dc   = 1'b0;
      mosi = i[0];
    end
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      mosi = ~mosi;
    end
    check_all_zero("midreset");
    rst = 1'b0;
    cs_idle(1);
    send_cmd(8'h2C);
    send_pix(16'h1234, 9'd0, 9'd0);
    send_pix(16'h5678, 9'd1, 9'd0);
    drain("midreset_drain");
    check("midreset_err", {31'd0, err}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
